// File: rtl/screen_sequencer.sv
// Multiplexes NUM_SCREENS VGA streams onto one registered output, switching at frame
// boundaries with BLANK_FRAMES black frames. Define SCREEN_FADE_EN for fade-out/fade-in instead.
module screen_sequencer #(
  parameter int NUM_SCREENS  = 4,
  parameter int SEL_W        = $clog2(NUM_SCREENS),
  parameter int INIT_SCREEN  = 0,
  parameter int BLANK_FRAMES = 2,
  parameter int CNT_W        = 11,
  parameter int RGB_W        = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [SEL_W-1:0]             req_screen,
  output logic                         req_ready,
  output logic                         req_err,
  output logic                         busy,
  output logic [SEL_W-1:0]             cur_screen,
  input  logic                         frame_vsync,
  input  logic [NUM_SCREENS*CNT_W-1:0] in_hcount,
  input  logic [NUM_SCREENS*CNT_W-1:0] in_vcount,
  input  logic [NUM_SCREENS-1:0]       in_hsync,
  input  logic [NUM_SCREENS-1:0]       in_vsync,
  input  logic [NUM_SCREENS-1:0]       in_hblnk,
  input  logic [NUM_SCREENS-1:0]       in_vblnk,
  input  logic [NUM_SCREENS*RGB_W-1:0] in_rgb,
  output logic [CNT_W-1:0]             out_hcount,
  output logic [CNT_W-1:0]             out_vcount,
  output logic                         out_hsync,
  output logic                         out_vsync,
  output logic                         out_hblnk,
  output logic                         out_vblnk,
  output logic [RGB_W-1:0]             out_rgb
);
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } pix_t;

`ifdef SCREEN_FADE_EN
  typedef enum logic [1:0] {IDLE, ARMED, BLANK, FADE_IN} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, BLANK} state_t;
`endif

  localparam logic [3:0] LAST = 4'(BLANK_FRAMES == 0 ? 0 : BLANK_FRAMES - 1);

  pix_t [NUM_SCREENS-1:0] ch;
  pix_t                   sel;
  state_t                 state;
  logic [SEL_W-1:0]       pending;
  logic [3:0]             fcnt;
  logic                   vs_q, bnd;
  logic [RGB_W-1:0]       rgb_n;

  for (genvar i = 0; i < NUM_SCREENS; i++) begin : g_ch
    assign ch[i] = {in_hcount[i*CNT_W +: CNT_W], in_vcount[i*CNT_W +: CNT_W],
                    in_hsync[i], in_vsync[i], in_hblnk[i], in_vblnk[i],
                    in_rgb[i*RGB_W +: RGB_W]};
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SCREENS; i++)
      if (cur_screen == SEL_W'(i)) sel = ch[i];
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // bnd is a registered rising-edge strobe: high the cycle after vsync is first sampled high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vs_q <= 1'b0;
      bnd  <= 1'b0;
    end else begin
      vs_q <= frame_vsync;
      bnd  <= frame_vsync & ~vs_q;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cur_screen <= SEL_W'(INIT_SCREEN);
      pending    <= '0;
      fcnt       <= '0;
      req_err    <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (32'(req_screen) >= NUM_SCREENS) req_err <= 1'b1;
          else if (req_screen != cur_screen) begin
            pending <= req_screen;
            state   <= ARMED;
          end
        end
        ARMED: if (bnd) begin
          if (BLANK_FRAMES == 0) begin
            cur_screen <= pending;
            state      <= IDLE;
          end else begin
            fcnt  <= '0;
            state <= BLANK;
          end
        end
        BLANK: if (bnd) begin
          if (fcnt == LAST) begin
            cur_screen <= pending;
            fcnt       <= '0;
`ifdef SCREEN_FADE_EN
            state      <= FADE_IN;
`else
            state      <= IDLE;
`endif
          end else fcnt <= fcnt + 4'd1;
        end
`ifdef SCREEN_FADE_EN
        FADE_IN: if (bnd) begin
          if (fcnt == LAST) begin
            fcnt  <= '0;
            state <= IDLE;
          end else fcnt <= fcnt + 4'd1;
        end
`endif
        default: state <= IDLE;
      endcase
    end

`ifdef SCREEN_FADE_EN
  localparam int CW = RGB_W / 3;
  logic [4:0] rem;
  assign rem = 5'(BLANK_FRAMES) - {1'b0, fcnt};

  function automatic logic [RGB_W-1:0] dim(input logic [RGB_W-1:0] c, input logic [2:0] s);
    dim = '0;
    for (int k = 0; k < 3; k++) dim[k*CW +: CW] = c[k*CW +: CW] >> s;
  endfunction
`endif

  always_comb begin
    rgb_n = sel.rgb;
`ifdef SCREEN_FADE_EN
    // fade-out shifts by min(k+1,4); fade-in mirrors it, min(BLANK_FRAMES-k,4)
    if (state == BLANK) rgb_n = dim(sel.rgb, (fcnt >= 4'd3) ? 3'd4 : 3'(fcnt + 4'd1));
    else if (state == FADE_IN) rgb_n = dim(sel.rgb, (rem >= 5'd4) ? 3'd4 : rem[2:0]);
`else
    if (state == BLANK) rgb_n = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
    end else begin
      out_hcount <= sel.hcount;
      out_vcount <= sel.vcount;
      out_hsync  <= sel.hsync;
      out_vsync  <= sel.vsync;
      out_hblnk  <= sel.hblnk;
      out_vblnk  <= sel.vblnk;
      out_rgb    <= rgb_n;
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench: per-frame expectations queued at request time, popped at mid-frame.
module tb_screen_sequencer;
  localparam int NS = 4, SW = 3, CW = 11, RW = 12, FL = 40, B = 2;

  logic clk, rst, req_valid, req_valid0, frame_vsync;
  logic [SW-1:0] req_screen;
  logic [NS*CW-1:0] in_hcount, in_vcount;
  logic [NS-1:0] in_hsync, in_vsync, in_hblnk, in_vblnk;
  logic [NS*RW-1:0] in_rgb;

  logic req_ready, req_err, busy, out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [SW-1:0] cur_screen;
  logic [CW-1:0] out_hcount, out_vcount;
  logic [RW-1:0] out_rgb;
  logic req_ready0, req_err0, busy0, out_hsync0, out_vsync0, out_hblnk0, out_vblnk0;
  logic [SW-1:0] cur_screen0;
  logic [CW-1:0] out_hcount0, out_vcount0;
  logic [RW-1:0] out_rgb0;

  screen_sequencer #(.NUM_SCREENS(NS), .SEL_W(SW), .INIT_SCREEN(0), .BLANK_FRAMES(B),
                     .CNT_W(CW), .RGB_W(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_screen(req_screen),
    .req_ready(req_ready), .req_err(req_err), .busy(busy), .cur_screen(cur_screen),
    .frame_vsync(frame_vsync), .in_hcount(in_hcount), .in_vcount(in_vcount),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
    .in_rgb(in_rgb), .out_hcount(out_hcount), .out_vcount(out_vcount),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblnk(out_hblnk),
    .out_vblnk(out_vblnk), .out_rgb(out_rgb));

  screen_sequencer #(.NUM_SCREENS(NS), .SEL_W(SW), .INIT_SCREEN(0), .BLANK_FRAMES(0),
                     .CNT_W(CW), .RGB_W(RW)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_screen(req_screen),
    .req_ready(req_ready0), .req_err(req_err0), .busy(busy0), .cur_screen(cur_screen0),
    .frame_vsync(frame_vsync), .in_hcount(in_hcount), .in_vcount(in_vcount),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
    .in_rgb(in_rgb), .out_hcount(out_hcount0), .out_vcount(out_vcount0),
    .out_hsync(out_hsync0), .out_vsync(out_vsync0), .out_hblnk(out_hblnk0),
    .out_vblnk(out_vblnk0), .out_rgb(out_rgb0));

  typedef struct {
    logic [RW-1:0] rgb;
    logic [SW-1:0] cur;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  logic [RW-1:0] rgbs [NS] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};
  int checks = 0, failures = 0, fcnt = FL - 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [RW-1:0] shr(input logic [RW-1:0] c, input int s);
    return {c[11:8] >> s, c[7:4] >> s, c[3:0] >> s};
  endfunction

  function automatic int min4(input int a);
    return (a > 4) ? 4 : a;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    fcnt = (fcnt == FL - 1) ? 0 : fcnt + 1;
    frame_vsync = (fcnt < 4);
  endtask

  task automatic goto(input int pos);
    do tick(); while (fcnt != pos);
  endtask

  task automatic push_switch(input int old_s, input int new_s);
    exp_t e;
    for (int k = 0; k < B; k++) begin
`ifdef SCREEN_FADE_EN
      e.rgb = shr(rgbs[old_s], min4(k + 1));
`else
      e.rgb = '0;
`endif
      e.cur = SW'(old_s); e.busy = 1'b1; sb.push_back(e);
    end
`ifdef SCREEN_FADE_EN
    for (int k = 0; k < B; k++) begin
      e.rgb = shr(rgbs[new_s], min4(B - k)); e.cur = SW'(new_s); e.busy = 1'b1;
      sb.push_back(e);
    end
`endif
    e.rgb = rgbs[new_s]; e.cur = SW'(new_s); e.busy = 1'b0; sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      goto(20);
      e = sb.pop_front();
      checks++; if (out_rgb !== e.rgb) begin failures++; $display("FAIL sb_rgb got=%h exp=%h", out_rgb, e.rgb); end
      checks++; if (cur_screen !== e.cur) begin failures++; $display("FAIL sb_cur got=%0d exp=%0d", cur_screen, e.cur); end
      checks++; if (busy !== e.busy) begin failures++; $display("FAIL sb_busy got=%b exp=%b", busy, e.busy); end
      checks++; if (out_hcount !== CW'(100 + e.cur)) begin failures++; $display("FAIL sb_hcount got=%0d exp=%0d", out_hcount, 100 + e.cur); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_screen = '0; frame_vsync = 1'b0;
    for (int i = 0; i < NS; i++) begin
      in_hcount[i*CW +: CW] = CW'(100 + i);
      in_vcount[i*CW +: CW] = CW'(200 + i);
      in_rgb[i*RW +: RW] = rgbs[i];
    end
    in_hsync = 4'b0101; in_vsync = 4'b0011; in_hblnk = 4'b1001; in_vblnk = 4'b0110;
    tick(); tick();
    checks++; if (out_rgb !== '0) begin failures++; $display("FAIL rst_rgb got=%h exp=0", out_rgb); end
    checks++; if (cur_screen !== 3'd0) begin failures++; $display("FAIL rst_cur got=%0d exp=0", cur_screen); end
    checks++; if ({req_ready, busy, req_err} !== 3'b100) begin failures++; $display("FAIL rst_flags got=%b exp=100", {req_ready, busy, req_err}); end
    rst = 1'b1;
    tick();
    checks++; if (out_rgb !== 12'hF00) begin failures++; $display("FAIL rel_rgb got=%h exp=f00", out_rgb); end
    checks++; if ({out_hcount, out_vcount} !== {11'd100, 11'd200}) begin failures++; $display("FAIL rel_cnt got=%0d/%0d exp=100/200", out_hcount, out_vcount); end
    checks++; if ({out_hsync, out_vsync, out_hblnk, out_vblnk} !== 4'b1110) begin failures++; $display("FAIL rel_sync got=%b exp=1110", {out_hsync, out_vsync, out_hblnk, out_vblnk}); end
  endtask

  task automatic test_switch_blank();
    goto(20);
    req_screen = 3'd1; req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sw_ready got=%b exp=1", req_ready); end
    tick();
    req_screen = 3'd2;  // second request while ARMED must be ignored
    checks++; if ({busy, req_ready} !== 2'b10) begin failures++; $display("FAIL sw_busy got=%b exp=10", {busy, req_ready}); end
    push_switch(0, 1);
    tick(); tick();
    checks++; if ({busy, req_ready, req_err} !== 3'b100) begin failures++; $display("FAIL sw_second got=%b exp=100", {busy, req_ready, req_err}); end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_err_and_same();
    exp_t e;
    req_screen = 3'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if ({req_err, busy} !== 2'b10) begin failures++; $display("FAIL err_pulse got=%b exp=10", {req_err, busy}); end
    tick();
    checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL err_width got=%b exp=0", req_err); end
    checks++; if (cur_screen !== 3'd1) begin failures++; $display("FAIL err_cur got=%0d exp=1", cur_screen); end
    req_screen = 3'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if ({busy, req_ready} !== 2'b01) begin failures++; $display("FAIL same_busy got=%b exp=01", {busy, req_ready}); end
    e.rgb = rgbs[1]; e.cur = 3'd1; e.busy = 1'b0;
    sb.push_back(e); sb.push_back(e);
    drain();
  endtask

  task automatic test_direct();
    goto(20);
    req_screen = 3'd3; req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL dir_busy got=%b exp=1", busy0); end
    goto(1);
    checks++; if ({cur_screen0, busy0} !== {3'd0, 1'b1}) begin failures++; $display("FAIL dir_early got=%0d/%b exp=0/1", cur_screen0, busy0); end
    tick();
    checks++; if ({cur_screen0, busy0} !== {3'd3, 1'b0}) begin failures++; $display("FAIL dir_switch got=%0d/%b exp=3/0", cur_screen0, busy0); end
    checks++; if (out_rgb0 !== 12'hF00) begin failures++; $display("FAIL dir_noblack got=%h exp=f00", out_rgb0); end
    tick();
    checks++; if (out_rgb0 !== 12'hFF0) begin failures++; $display("FAIL dir_new got=%h exp=ff0", out_rgb0); end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] exp_b;
    goto(20);
    req_screen = 3'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    goto(20);
`ifdef SCREEN_FADE_EN
    exp_b = shr(rgbs[1], 1);
`else
    exp_b = '0;
`endif
    checks++; if ({out_rgb, busy} !== {exp_b, 1'b1}) begin failures++; $display("FAIL mid_blank got=%h/%b exp=%h/1", out_rgb, busy, exp_b); end
    #3 rst = 1'b0;
    #1;
    checks++; if ({out_rgb, out_hcount} !== '0) begin failures++; $display("FAIL mid_async got=%h/%0d exp=0/0", out_rgb, out_hcount); end
    checks++; if ({cur_screen, busy} !== {3'd0, 1'b0}) begin failures++; $display("FAIL mid_cur got=%0d/%b exp=0/0", cur_screen, busy); end
    @(negedge clk) rst = 1'b1;
    tick();
    checks++; if ({out_rgb, cur_screen, busy} !== {12'hF00, 3'd0, 1'b0}) begin failures++; $display("FAIL mid_release got=%h/%0d/%b exp=f00/0/0", out_rgb, cur_screen, busy); end
  endtask

  initial begin
    test_reset();
    test_switch_blank();
    test_err_and_same();
    test_direct();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
